uart_trx_param: RTL and testbench

UART_TRX_PARAM -- requirements
Module: uart_trx_param

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_fifo.sv | 84 ++++++++
 rtl/uart_trx_param.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_uart_trx_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX/RX FSM state encodings and the
// parity-bit helper used by both directions.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_e;

    // Parity bit that goes on the wire, given the XOR-reduction of the data.
    function automatic logic par_bit(input logic data_xor, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO for received bytes.
// Ports: clk/rst (async active-high), push/push_data write side,
// pop read side, head = registered head entry (holds last value when empty),
// valid = not empty, full, count = occupancy.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             push_ok, pop_ok;

    // Pointer/count update; a pop frees a slot for a same-cycle push when full.
    always_comb begin
        pop_ok   = pop && valid_q;
        push_ok  = push && (!full_q || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        valid_d = (count_d != '0);
        full_d  = (count_d == CNT_W'(DEPTH));
        // Pre-compute next head; the write port bypasses when the FIFO drains to it.
        head_d = head_q;
        if (valid_d) begin
            head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign head  = head_q;
    assign valid = valid_q;
    assign full  = full_q;
    assign count = count_q;

endmodule

// File: rtl/uart_trx_param.sv
// Parametrised full-duplex UART with an RX FIFO.
// Ports: clk, rst (async active-high); TX: tx_data/tx_valid/tx_ready handshake,
// txd serial out; RX: rxd serial in, rx_data/rx_valid/rx_ready show-ahead FIFO,
// rx_frame_err/rx_par_err one-cycle pulses, rx_overrun sticky, rx_count occupancy.
module uart_trx_param
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CLKS  = 434,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned RXF_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        txd,
    input  logic                        rxd,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        rx_frame_err,
    output logic                        rx_par_err,
    output logic                        rx_overrun,
    output logic [$clog2(RXF_DEPTH):0]  rx_count
);

    localparam int unsigned CNT_W = $clog2(BIT_CLKS);
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam bit HAS_PAR  = (PARITY != PARITY_NONE);
    localparam bit TWO_STOP = (STOP_BITS == 2);

    // ---------------- TX ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0]  tx_idx_q, tx_idx_d, tx_idx_nx;
    logic              tx_stop_q, tx_stop_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              txd_q, txd_d;
    logic              tx_ready_q, tx_ready_d;
    logic              tx_bit_end;

    // txd is registered alongside the state, so each bit lasts exactly BIT_CLKS.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_stop_d  = tx_stop_q;
        tx_buf_d   = tx_buf_q;
        txd_d      = txd_q;
        tx_ready_d = tx_ready_q;
        tx_bit_end = (tx_cnt_q == BIT_LAST);
        tx_idx_nx  = tx_idx_q + IDX_W'(1);
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CNT_W'(1);
        end
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    tx_buf_d   = tx_data;
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_idx_d   = '0;
                    txd_d      = tx_buf_q[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == IDX_LAST) begin
                        if (HAS_PAR) begin
                            tx_state_d = TX_PAR;
                            txd_d      = par_bit(^tx_buf_q, PARITY);
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_stop_d  = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tx_idx_d = tx_idx_nx;
                        txd_d    = tx_buf_q[tx_idx_nx];
                    end
                end
            end
            TX_PAR: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_stop_d  = 1'b0;
                    txd_d      = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (!TWO_STOP || tx_stop_q) begin
                        tx_state_d = TX_IDLE;
                        tx_ready_d = 1'b1;
                        txd_d      = 1'b1;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_ready_d = 1'b1;
                txd_d      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_buf_q   <= '0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_stop_q  <= tx_stop_d;
            tx_buf_q   <= tx_buf_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign txd      = txd_q;
    assign tx_ready = tx_ready_q;

    // ---------------- RX ----------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
    logic              rx_stop_q, rx_stop_d;
    logic              rx_stop_bad_q, rx_stop_bad_d;
    logic              rx_par_q, rx_par_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rxd_meta_q, rxd_meta_d;
    logic              rxd_sync_q, rxd_sync_d;
    logic              rxd_prev_q, rxd_prev_d;
    logic              rx_frame_err_q, rx_frame_err_d;
    logic              rx_par_err_q, rx_par_err_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              rx_fall, rx_bit_end, rx_bad;
    logic              rx_push_c;
    logic              fifo_valid, fifo_full, fifo_drop_c;

    // Sampling FSM: start checked at half a bit, later bits at their centres.
    always_comb begin
        rxd_meta_d     = rxd;
        rxd_sync_d     = rxd_meta_q;
        rxd_prev_d     = rxd_sync_q;
        rx_state_d     = rx_state_q;
        rx_cnt_d       = rx_cnt_q;
        rx_idx_d       = rx_idx_q;
        rx_stop_d      = rx_stop_q;
        rx_stop_bad_d  = rx_stop_bad_q;
        rx_par_d       = rx_par_q;
        rx_shift_d     = rx_shift_q;
        rx_frame_err_d = 1'b0;
        rx_par_err_d   = 1'b0;
        rx_push_c      = 1'b0;
        rx_bad         = rx_stop_bad_q || !rxd_sync_q;
        rx_fall        = rxd_prev_q && !rxd_sync_q;
        rx_bit_end     = (rx_state_q == RX_START) ? (rx_cnt_q == HALF_LAST)
                                                  : (rx_cnt_q == BIT_LAST);
        if (rx_state_q != RX_IDLE) begin
            rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + CNT_W'(1);
        end
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_bit_end) begin
                    if (rxd_sync_q) begin
                        rx_state_d = RX_IDLE;       // false start
                    end else begin
                        rx_state_d    = RX_DATA;
                        rx_idx_d      = '0;
                        rx_stop_bad_d = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_W-1:1]};
                    if (rx_idx_q == IDX_LAST) begin
                        rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
                        rx_stop_d  = 1'b0;
                    end else begin
                        rx_idx_d = rx_idx_q + IDX_W'(1);
                    end
                end
            end
            RX_PAR: begin
                if (rx_bit_end) begin
                    rx_par_d   = rxd_sync_q;
                    rx_state_d = RX_STOP;
                    rx_stop_d  = 1'b0;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    if (!TWO_STOP || rx_stop_q) begin
                        rx_state_d     = RX_IDLE;
                        rx_frame_err_d = rx_bad;
                        rx_par_err_d   = HAS_PAR && (rx_par_q != par_bit(^rx_shift_q, PARITY));
                        rx_push_c      = !rx_bad && !rx_par_err_d;
                    end else begin
                        rx_stop_bad_d = rx_bad;
                        rx_stop_d     = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        rx_overrun_d = rx_overrun_q || fifo_drop_c;
    end

    // A push is lost only when the FIFO is full and not popped this cycle.
    assign fifo_drop_c = rx_push_c && fifo_full && !(rx_ready && fifo_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= '0;
            rx_idx_q       <= '0;
            rx_stop_q      <= 1'b0;
            rx_stop_bad_q  <= 1'b0;
            rx_par_q       <= 1'b0;
            rx_shift_q     <= '0;
            rxd_meta_q     <= 1'b1;
            rxd_sync_q     <= 1'b1;
            rxd_prev_q     <= 1'b1;
            rx_frame_err_q <= 1'b0;
            rx_par_err_q   <= 1'b0;
            rx_overrun_q   <= 1'b0;
        end else begin
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_idx_q       <= rx_idx_d;
            rx_stop_q      <= rx_stop_d;
            rx_stop_bad_q  <= rx_stop_bad_d;
            rx_par_q       <= rx_par_d;
            rx_shift_q     <= rx_shift_d;
            rxd_meta_q     <= rxd_meta_d;
            rxd_sync_q     <= rxd_sync_d;
            rxd_prev_q     <= rxd_prev_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_par_err_q   <= rx_par_err_d;
            rx_overrun_q   <= rx_overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RXF_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push_c),
        .push_data (rx_shift_q),
        .pop       (rx_ready),
        .head      (rx_data),
        .valid     (fifo_valid),
        .full      (fifo_full),
        .count     (rx_count)
    );

    assign rx_valid     = fifo_valid;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_par_err   = rx_par_err_q;
    assign rx_overrun   = rx_overrun_q;

endmodule

// File: tb/tb_uart_trx_param.sv
// Bench for uart_trx_param at BIT_CLKS=16: instance A (no parity) and
// instance B (even parity). Received bytes on A are checked against a queue.
module tb_uart_trx_param;

    localparam int unsigned BIT_CLKS = 16;

    logic clk = 1'b0;
    logic rst;

    logic [7:0] tx_data_a, rx_data_a;
    logic       tx_valid_a, tx_ready_a, txd_a, rxd_a;
    logic       rx_valid_a, rx_ready_a, rx_frame_err_a, rx_par_err_a, rx_overrun_a;
    logic [2:0] rx_count_a;

    logic [7:0] tx_data_b, rx_data_b;
    logic       tx_valid_b, tx_ready_b, txd_b;
    logic       rx_valid_b, rx_ready_b, rx_frame_err_b, rx_par_err_b, rx_overrun_b;
    logic [2:0] rx_count_b;

    logic loop_a, inj_a, inj_b;
    assign rxd_a = loop_a ? txd_a : inj_a;

    always #5 clk = ~clk;

    uart_trx_param #(
        .BIT_CLKS(BIT_CLKS), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .RXF_DEPTH(4)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .txd(txd_a),
        .rxd(rxd_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_frame_err(rx_frame_err_a), .rx_par_err(rx_par_err_a),
        .rx_overrun(rx_overrun_a), .rx_count(rx_count_a)
    );

    uart_trx_param #(
        .BIT_CLKS(BIT_CLKS), .DATA_W(8), .PARITY(1), .STOP_BITS(1), .RXF_DEPTH(4)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .txd(txd_b),
        .rxd(inj_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_frame_err(rx_frame_err_b), .rx_par_err(rx_par_err_b),
        .rx_overrun(rx_overrun_b), .rx_count(rx_count_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int frame_a = 0, par_a = 0, frame_b = 0, par_b = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Error pulse counters and scoreboard pop, sampled between clock edges.
    always @(negedge clk) begin
        if (rx_frame_err_a) frame_a++;
        if (rx_par_err_a)   par_a++;
        if (rx_frame_err_b) frame_b++;
        if (rx_par_err_b)   par_b++;
        if (rx_valid_a && rx_ready_a) begin
            if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_data_a), 32'hFFFF_FFFF);
            else                   check("rx_byte", 32'(rx_data_a), 32'(exp_q.pop_front()));
        end
    end

    // Drive one serial frame on A's or B's rxd, followed by one idle bit time.
    task automatic inject(input bit to_b, input logic [8:0] data, input int nd,
                          input bit has_par, input bit par, input bit stop);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(data[i]);
        if (has_par) bits.push_back(par);
        bits.push_back(stop);
        foreach (bits[k]) begin
            if (to_b) inj_b = bits[k];
            else      inj_a = bits[k];
            tick(BIT_CLKS);
        end
        if (to_b) inj_b = 1'b1;
        else      inj_a = 1'b1;
        tick(BIT_CLKS);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 0);
    endtask

    task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int nb);
        logic [7:0] lb [3];
        int wait_n;
        lb[0] = b0; lb[1] = b1; lb[2] = b2;
        for (int i = 0; i < nb; i++) begin
            tx_data_a  = lb[i];
            tx_valid_a = 1'b1;
            exp_q.push_back(lb[i]);
            wait_n = 0;
            while (!tx_ready_a && wait_n < 400) begin
                tick(1);
                wait_n++;
            end
            if (!tx_ready_a) check("tx_ready_timeout", 32'(tx_ready_a), 1);
            tick(1);
        end
        tx_valid_a = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        logic [7:0] ov [5];
        int low, f0, p0;

        rst = 1'b0; loop_a = 1'b0; inj_a = 1'b1; inj_b = 1'b1;
        tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b1;
        tx_data_b = '0; tx_valid_b = 1'b0; rx_ready_b = 1'b0;
        #2 rst = 1'b1;
        tick(3);
        check("rst_txd",      32'(txd_a), 1);
        check("rst_tx_ready", 32'(tx_ready_a), 1);
        check("rst_rx_valid", 32'(rx_valid_a), 0);
        check("rst_rx_count", 32'(rx_count_a), 0);
        check("rst_rx_data",  32'(rx_data_a), 0);
        check("rst_overrun",  32'(rx_overrun_a), 0);
        check("rst_errs",     32'({rx_frame_err_a, rx_par_err_a}), 0);
        check("rst_b_txd",    32'({txd_b, tx_ready_b}), 32'h3);
        rst = 1'b0;
        tick(4);

        // Single 0xA5 frame, bit by bit.
        frame = {1'b1, 8'hA5, 1'b0};
        tx_data_a = 8'hA5; tx_valid_a = 1'b1;
        tick(1);
        tx_valid_a = 1'b0;
        low = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < int'(BIT_CLKS); c++) begin
                check($sformatf("txd_a5_bit%0d", b), 32'(txd_a), 32'(frame[b]));
                if (!tx_ready_a) low++;
                tick(1);
            end
        end
        check("tx_ready_low_cycles", 32'(low), 160);
        check("tx_ready_after", 32'(tx_ready_a), 1);
        tick(5);

        // Loopback, three back-to-back bytes.
        loop_a = 1'b1;
        tick(2);
        f0 = frame_a; p0 = par_a;
        send_bytes(8'h00, 8'hFF, 8'h3C, 3);
        wait_drain(800);
        check("loop_frame_err", 32'(frame_a - f0), 0);
        check("loop_par_err",   32'(par_a - p0), 0);
        check("loop_count",     32'(rx_count_a), 0);
        tick(2 * BIT_CLKS);
        loop_a = 1'b0;
        tick(4);

        // Stop bit low, then a short glitch on idle.
        f0 = frame_a; p0 = par_a;
        inject(1'b0, 9'h055, 8, 1'b0, 1'b0, 1'b0);
        check("ferr_pulse",   32'(frame_a - f0), 1);
        check("ferr_no_par",  32'(par_a - p0), 0);
        check("ferr_no_push", 32'(rx_count_a), 0);
        inj_a = 1'b0;
        tick(4);
        inj_a = 1'b1;
        tick(40);
        check("glitch_ferr",  32'(frame_a - f0), 1);
        check("glitch_valid", 32'(rx_valid_a), 0);
        check("glitch_count", 32'(rx_count_a), 0);

        // Five bytes into a depth-4 FIFO with the consumer stalled.
        rx_ready_a = 1'b0;
        ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33; ov[3] = 8'h44; ov[4] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(ov[i]);
            inject(1'b0, {1'b0, ov[i]}, 8, 1'b0, 1'b0, 1'b1);
        end
        tick(4);
        check("ovr_count",   32'(rx_count_a), 4);
        check("ovr_flag",    32'(rx_overrun_a), 1);
        check("ovr_valid",   32'(rx_valid_a), 1);
        check("ovr_head",    32'(rx_data_a), 32'h11);
        rx_ready_a = 1'b1;
        wait_drain(20);
        tick(1);
        check("ovr_drained", 32'(rx_count_a), 0);
        check("ovr_sticky",  32'(rx_overrun_a), 1);

        // Even parity on B: bad then good frames.
        inject(1'b1, 9'h007, 8, 1'b1, 1'b0, 1'b1);
        check("par_pulse",    32'(par_b), 1);
        check("par_no_ferr",  32'(frame_b), 0);
        check("par_no_push",  32'(rx_count_b), 0);
        inject(1'b1, 9'h007, 8, 1'b1, 1'b1, 1'b1);
        inject(1'b1, 9'h003, 8, 1'b1, 1'b0, 1'b1);
        check("par_good_cnt", 32'(rx_count_b), 2);
        check("par_good_hd",  32'(rx_data_b), 32'h07);
        check("par_no_more",  32'(par_b), 1);

        // Asynchronous reset in the middle of a TX frame.
        f0 = frame_a; p0 = par_a;
        tx_data_a = 8'hA5; tx_valid_a = 1'b1;
        tick(1);
        tx_valid_a = 1'b0;
        tick(39);
        check("mid_txd",      32'(txd_a), 0);
        check("mid_tx_ready", 32'(tx_ready_a), 0);
        #2 rst = 1'b1;
        #1;
        check("arst_txd",      32'(txd_a), 1);
        check("arst_tx_ready", 32'(tx_ready_a), 1);
        check("arst_overrun",  32'(rx_overrun_a), 0);
        tick(2);
        rst = 1'b0;
        tick(2 * BIT_CLKS * 10);
        check("arst_txd_idle", 32'(txd_a), 1);
        check("arst_no_err",   32'((frame_a - f0) + (par_a - p0)), 0);

        // Recovery: one more loopback byte.
        loop_a = 1'b1;
        tick(2);
        send_bytes(8'h5A, 8'h00, 8'h00, 1);
        wait_drain(400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
